// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one 16-bit instruction word at a time,
// holds it until the decode stage acknowledges it, then advances or
// redirects the PC.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

  // Instructions are halfword aligned, so the PC never carries bit 0.
  localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'h1;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

  // State, PC and held instruction; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= ResetPcAligned;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic: stall only gates starting a fetch, never aborts one.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StIdle: begin
        if (!stall) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_ack) begin
          // pc + 2 wraps naturally at 2^32.
          pc_d    = branch_taken ? (branch_target & ~32'h1) : (pc_q + 32'd2);
          state_d = stall ? StIdle : StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs come straight from registers or the decoded state.
  always_comb begin
    mem_req     = (state_q == StFetch);
    instr_valid = (state_q == StHold);
    mem_addr    = pc_q;
    pc          = pc_q;
    instr       = instr_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scripted stimulus with a scoreboard
// of returned memory words compared against the held instruction.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;

  // Second instance with an odd reset PC to check bit-0 clearing.
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [15:0] o_instr;
  logic        o_instr_valid;
  logic [31:0] o_pc;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [31:0] exp_pc;

  instr_fetch #(
    .RESET_PC(32'h0000_0000)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ack    (instr_ack),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc)
  );

  instr_fetch #(
    .RESET_PC(32'h0000_1235)
  ) u_dut_odd (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .mem_req      (o_mem_req),
    .mem_addr     (o_mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .instr        (o_instr),
    .instr_valid  (o_instr_valid),
    .instr_ack    (instr_ack),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expects the DUT in FETCH at exp_pc; answers after 'waits' idle cycles.
  task automatic fetch_one(input int waits, input logic stall_wait, input logic [15:0] word);
    for (int i = 0; i < waits; i++) begin
      check_eq("wait_req", {31'b0, mem_req}, 32'd1);
      check_eq("wait_addr", mem_addr, exp_pc);
      check_eq("wait_valid", {31'b0, instr_valid}, 32'd0);
      stall     = stall_wait;
      mem_ready = 1'b0;
      step();
    end
    check_eq("fetch_req", {31'b0, mem_req}, 32'd1);
    check_eq("fetch_addr", mem_addr, exp_pc);
    check_eq("fetch_valid", {31'b0, instr_valid}, 32'd0);
    stall     = stall_wait;
    mem_ready = 1'b1;
    mem_rdata = word;
    exp_q.push_back(word);
    step();
    mem_ready = 1'b0;
    mem_rdata = 16'hDEAD;
    stall     = 1'b0;
    check_eq("hold_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("hold_req", {31'b0, mem_req}, 32'd0);
    check_eq("hold_pc", pc, exp_pc);
    check_eq("sb_size", exp_q.size(), 32'd1);
    if (exp_q.size() != 0) begin
      check_eq("instr", {16'b0, instr}, {16'b0, exp_q.pop_front()});
    end
  endtask

  // Acknowledges the held instruction from HOLD.
  task automatic ack(input logic br, input logic [31:0] tgt, input logic st);
    instr_ack     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    stall         = st;
    exp_pc        = br ? (tgt & ~32'h1) : (exp_pc + 32'd2);
    step();
    instr_ack    = 1'b0;
    branch_taken = 1'b0;
    check_eq("ack_pc", pc, exp_pc);
    check_eq("ack_addr", mem_addr, exp_pc);
    check_eq("ack_req", {31'b0, mem_req}, {31'b0, !st});
    check_eq("ack_valid", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    mem_ready     = 1'b0;
    mem_rdata     = 16'h0000;
    instr_ack     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    exp_pc        = 32'h0;
    repeat (2) step();

    // Reset state
    check_eq("rst_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_instr", {16'b0, instr}, 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_odd_pc", o_pc, 32'h0000_1234);
    check_eq("rst_odd_addr", o_mem_addr, 32'h0000_1234);

    rst = 1'b0;
    #1;
    check_eq("idle_req", {31'b0, mem_req}, 32'd0);
    step();

    // Sequential run: 0x0, 0x2, 0x4
    fetch_one(0, 1'b0, 16'h1111);
    ack(1'b0, 32'h0, 1'b0);
    fetch_one(0, 1'b0, 16'h2222);
    ack(1'b0, 32'h0, 1'b0);
    fetch_one(0, 1'b0, 16'h3333);
    ack(1'b0, 32'h0, 1'b0);

    // Memory wait with stall rising mid-request
    fetch_one(3, 1'b1, 16'h4444);

    // Branch to 0x10, then 0x101 -> 0x100
    ack(1'b1, 32'h0000_0010, 1'b0);
    fetch_one(0, 1'b0, 16'h4321);
    ack(1'b1, 32'h0000_0101, 1'b0);
    fetch_one(0, 1'b0, 16'h5555);

    // Backpressure: branch_taken without ack is ignored
    for (int i = 0; i < 5; i++) begin
      instr_ack     = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0200;
      step();
      check_eq("bp_valid", {31'b0, instr_valid}, 32'd1);
      check_eq("bp_instr", {16'b0, instr}, 32'h0000_5555);
      check_eq("bp_pc", pc, 32'h0000_0100);
    end
    branch_taken = 1'b0;

    // Ack under stall goes to IDLE; ack/branch in IDLE are ignored
    ack(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stall         = 1'b1;
      instr_ack     = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0300;
      step();
      check_eq("stall_req", {31'b0, mem_req}, 32'd0);
      check_eq("stall_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("stall_pc", pc, 32'h0000_0102);
    end
    instr_ack    = 1'b0;
    branch_taken = 1'b0;
    stall        = 1'b0;
    step();
    fetch_one(0, 1'b0, 16'h6666);

    // Wrap from 0xFFFFFFFE to 0x0
    ack(1'b1, 32'hFFFF_FFFF, 1'b0);
    check_eq("wrap_pc_hi", pc, 32'hFFFF_FFFE);
    fetch_one(0, 1'b0, 16'hABCD);
    ack(1'b0, 32'h0, 1'b0);
    check_eq("wrap_pc_lo", pc, 32'h0);
    fetch_one(0, 1'b0, 16'h1357);

    // Reset mid-FETCH with a late mem_ready
    ack(1'b1, 32'h0000_0041, 1'b0);
    #2;
    rst       = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    check_eq("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check_eq("mid_rst_pc", pc, 32'h0);
    check_eq("mid_rst_instr", {16'b0, instr}, 32'd0);
    check_eq("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("post_rst_req", {31'b0, mem_req}, 32'd0);
    check_eq("post_rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("post_rst_instr", {16'b0, instr}, 32'd0);
    mem_ready = 1'b0;
    exp_pc    = 32'h0;
    step();
    fetch_one(0, 1'b0, 16'h7777);
    ack(1'b0, 32'h0, 1'b0);

    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
